mini_alu_16bit_div_sched: RTL and testbench
===========================================

MINI_ALU_16BIT_DIV_SCHED -- requirements
Module: mini_alu_16bit_div_sched

Interface
REQ-001 The block SHALL have the parameter N_REQ, default 4, giving the number of requesters sharing one mini_ALU_16bit_DIV instance.
REQ-002 The block SHALL have the parameter TIMEOUT, default 40, giving the maximum number of WAIT cycles before an error response.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have the port req_valid, input, N_REQ bits: per-requester request strobe.
REQ-006 The block SHALL have the port req_X, input, N_REQ*16 bits: packed dividends; requester i uses bits [16i+15:16i].
REQ-007 The block SHALL have the port req_Y, input, N_REQ*16 bits: packed divisors, using the same packing as req_X.
REQ-008 The block SHALL have the port req_ready, output, N_REQ bits: acceptance strobe, one-hot or zero.
REQ-009 The block SHALL have the port rsp_valid, output, 1 bit: one-cycle response pulse.
REQ-010 The block SHALL have the port rsp_id, output, clog2(N_REQ) bits: index of the requester the response belongs to.
REQ-011 The block SHALL have the ports rsp_quot and rsp_rem, outputs, 16 bits each: the response quotient and remainder.
REQ-012 The block SHALL have the ports rsp_dz and rsp_err, outputs, 1 bit each: divide-by-zero flag and timeout flag.
REQ-013 The block SHALL have the ports div_start (output, 1 bit), div_X (output, 16 bits) and div_Y (output, 16 bits), which drive the divider.
REQ-014 The block SHALL have the ports div_valid (input, 1 bit), div_quot (input, 16 bits) and div_rem (input, 16 bits), which are the divider results.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP, and SHALL process exactly one operation at a time.
REQ-016 In IDLE, when req_valid is nonzero, the block SHALL grant round-robin, starting the search at rr_ptr and wrapping from N_REQ-1 to 0.
REQ-017 On a grant, the block SHALL pulse req_ready[g] for exactly that cycle, latch X, Y and g, and set rr_ptr to (g+1) mod N_REQ.
REQ-018 If the latched Y==0, the FSM SHALL go IDLE->RESP with rsp_dz=1, rsp_quot=16'hFFFF and rsp_rem=X, and the divider SHALL NOT be started.
REQ-019 If the latched Y!=0, the FSM SHALL go IDLE->ISSUE, and div_start SHALL be 1 only in ISSUE (one cycle), after which the FSM goes to WAIT.
REQ-020 div_X and div_Y SHALL hold the latched operands from ISSUE until the FSM leaves WAIT.
REQ-021 In WAIT, a cycle counter SHALL start at 0 and increment each cycle.
REQ-022 When div_valid=1 in WAIT, the block SHALL capture div_quot and div_rem and go to RESP.
REQ-023 When the counter reaches TIMEOUT-1 without div_valid, the FSM SHALL go to RESP with rsp_err=1 and zero quot/rem.
REQ-024 If div_valid and the timeout occur in the same cycle, div_valid SHALL win and rsp_err SHALL be 0.
REQ-025 div_valid SHALL be ignored outside WAIT.
REQ-026 In RESP, rsp_valid SHALL be 1 for one cycle, with rsp_id, data and flags stable, and the FSM SHALL then return to IDLE.
REQ-027 rsp_id, rsp_quot, rsp_rem, rsp_dz and rsp_err SHALL hold their values until the next RESP.
REQ-028 There SHALL be no response back-pressure: a requester must sample the response on rsp_valid.
REQ-029 A divide-by-zero response SHALL appear 1 cycle after the grant.
REQ-030 A normal response SHALL appear 1 cycle after div_valid, i.e. at grant + 2 + divider latency + 1.
REQ-031 req_ready SHALL be 0 in every non-IDLE state, and requests that are not granted SHALL be held by their requesters.

Reset
REQ-032 When rst=0, the block SHALL asynchronously set the FSM to IDLE, rr_ptr=0, counter=0 and all outputs to 0 (including div_start, req_ready and rsp_valid).
REQ-033 A reset during ISSUE, WAIT or RESP SHALL drop the in-flight operation with no response.
REQ-034 Release of rst SHALL be synchronous to clk, and the first grant is possible on the first rising edge after release.

Structure
REQ-035 The shared package mini_alu_div_pkg SHALL hold the FSM state typedef, the DZ_QUOT=16'hFFFF constant, and the default TIMEOUT.
REQ-036 The round-robin grant SHALL be implemented in the sub-module mini_alu_rr_arb (inputs req and ptr, outputs one-hot gnt and index).
REQ-037 The block SHALL contain one mini_ALU_16bit_DIV instance at the next level up, not inside this block.

Verification
REQ-038 The bench SHALL cover: a single request from requester 0 with X=15, Y=8 -> rsp_id=0, quot=1, rem=7, dz=0, err=0, with div_start pulsed exactly once.
REQ-039 The bench SHALL cover: all four requesters valid simultaneously with X=89, Y=21 -> grants in order 0,1,2,3, and four responses each giving quot=4, rem=5.
REQ-040 The bench SHALL cover: requester 2 with X=77, Y=0 -> rsp_valid 1 cycle after the grant, dz=1, quot=16'hFFFF, rem=77, and div_start never asserted.
REQ-041 The bench SHALL cover: div_valid forced low with TIMEOUT=40 -> rsp_err=1 with rsp_valid exactly 40 WAIT cycles after ISSUE, after which the block is idle and accepts a new request.
REQ-042 The bench SHALL cover: rst asserted mid-WAIT -> all outputs 0 immediately, no response, and rr_ptr=0 so requester 0 wins the next grant.
REQ-043 The bench SHALL cover: div_valid coinciding with the timeout cycle for X=10, Y=2 -> quot=5, rem=0, err=0.

Source files
------------

// File: rtl/mini_alu_div_pkg.sv
// Shared types and constants for the shared-divider request scheduler.
// No logic here; imported by the scheduler top.
package mini_alu_div_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [15:0] DZ_QUOT     = 16'hFFFF;
   localparam int          DEF_TIMEOUT = 40;

endpackage

// File: rtl/mini_alu_rr_arb.sv
// Round-robin grant: combinational, searches upward from ptr and wraps at N_REQ-1.
// No backpressure of its own; the caller decides when a grant is taken.
module mini_alu_rr_arb #(
   parameter int N_REQ = 4,
   parameter int IW    = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IW-1:0]    index
);

   // Scan farthest-to-nearest so the requester closest to ptr is written last and wins.
   always_comb begin
      int k;
      gnt   = '0;
      index = '0;
      k     = 0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         k = (int'(ptr) + i) % N_REQ;
         if (req[k]) begin
            gnt    = '0;
            gnt[k] = 1'b1;
            index  = IW'(k);
         end
      end
   end

endmodule

// File: rtl/mini_alu_16bit_div_sched.sv
// Shares one external 16-bit divider among N_REQ requesters, one operation at a time.
// Grant is combinational in IDLE; divide-by-zero answers 1 cycle after grant, others 1 cycle after div_valid; no response backpressure.
module mini_alu_16bit_div_sched
   import mini_alu_div_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*16-1:0]        req_X,
   input  logic [N_REQ*16-1:0]        req_Y,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       rsp_valid,
   output logic [$clog2(N_REQ)-1:0]   rsp_id,
   output logic [15:0]                rsp_quot,
   output logic [15:0]                rsp_rem,
   output logic                       rsp_dz,
   output logic                       rsp_err,
   output logic                       div_start,
   output logic [15:0]                div_X,
   output logic [15:0]                div_Y,
   input  logic                       div_valid,
   input  logic [15:0]                div_quot,
   input  logic [15:0]                div_rem
);

   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT) + 1;

   state_t           state;
   logic [IW-1:0]    rr_ptr;
   logic [IW-1:0]    cur_id;
   logic [IW-1:0]    gnt_idx;
   logic [N_REQ-1:0] gnt;
   logic [CW-1:0]    cnt;
   logic [15:0]      sel_x;
   logic [15:0]      sel_y;

   mini_alu_rr_arb #(.N_REQ(N_REQ), .IW(IW)) u_arb (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .gnt   (gnt),
      .index (gnt_idx)
   );

   assign sel_x = req_X[16*gnt_idx +: 16];
   assign sel_y = req_Y[16*gnt_idx +: 16];

   // Gated by rst so req_ready is forced low while reset is held.
   assign req_ready = (rst && state == IDLE) ? gnt : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         cur_id    <= '0;
         cnt       <= '0;
         div_start <= 1'b0;
         div_X     <= '0;
         div_Y     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_quot  <= '0;
         rsp_rem   <= '0;
         rsp_dz    <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         div_start <= 1'b0;
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  cur_id <= gnt_idx;
                  rr_ptr <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
                  div_X  <= sel_x;
                  div_Y  <= sel_y;
                  if (sel_y == '0) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_id    <= gnt_idx;
                     rsp_quot  <= DZ_QUOT;
                     rsp_rem   <= sel_x;
                     rsp_dz    <= 1'b1;
                     rsp_err   <= 1'b0;
                  end else begin
                     state     <= ISSUE;
                     div_start <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               state <= WAIT;
               cnt   <= '0;
            end
            WAIT: begin
               // A result arriving on the last allowed cycle still beats the timeout.
               if (div_valid) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_id    <= cur_id;
                  rsp_quot  <= div_quot;
                  rsp_rem   <= div_rem;
                  rsp_dz    <= 1'b0;
                  rsp_err   <= 1'b0;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_id    <= cur_id;
                  rsp_quot  <= '0;
                  rsp_rem   <= '0;
                  rsp_dz    <= 1'b0;
                  rsp_err   <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mini_alu_16bit_div_sched.sv
// Randomized and directed checks of the divider scheduler against a transaction-level model.
module tb_mini_alu_16bit_div_sched;

   localparam int N  = 4;
   localparam int T  = 40;
   localparam int QD = 64;

   typedef struct {
      int          id;
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
      logic        err;
      int          due;
   } exp_t;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*16-1:0] req_X;
   logic [N*16-1:0] req_Y;
   logic [N-1:0]    req_ready;
   logic            rsp_valid;
   logic [1:0]      rsp_id;
   logic [15:0]     rsp_quot;
   logic [15:0]     rsp_rem;
   logic            rsp_dz;
   logic            rsp_err;
   logic            div_start;
   logic [15:0]     div_X;
   logic [15:0]     div_Y;
   logic            div_valid;
   logic [15:0]     div_quot;
   logic [15:0]     div_rem;

   int   errors;
   int   checks;
   int   cyc;
   int   div_lat;
   int   starts;
   int   st_cyc;
   int   head [N];
   int   tail [N];
   logic [15:0] qx [N][QD];
   logic [15:0] qy [N][QD];
   exp_t exq [$];
   exp_t rl [$];
   int   gl_id [$];
   int   gl_cyc [$];

   mini_alu_16bit_div_sched #(.N_REQ(N), .TIMEOUT(T)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_X     (req_X),
      .req_Y     (req_Y),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_quot  (rsp_quot),
      .rsp_rem   (rsp_rem),
      .rsp_dz    (rsp_dz),
      .rsp_err   (rsp_err),
      .div_start (div_start),
      .div_X     (div_X),
      .div_Y     (div_Y),
      .div_valid (div_valid),
      .div_quot  (div_quot),
      .div_rem   (div_rem)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int i, input logic [15:0] x, input logic [15:0] y);
      qx[i][tail[i] % QD] = x;
      qy[i][tail[i] % QD] = y;
      tail[i]++;
   endtask

   function automatic int pending();
      int p = 0;
      for (int i = 0; i < N; i++) p += tail[i] - head[i];
      return p;
   endfunction

   task automatic wait_idle(input int budget);
      int n = 0;
      repeat (2) @(posedge clk);
      while (!(pending() == 0 && exq.size() == 0 && req_valid == '0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (n >= budget) begin
         checks++;
         errors++;
         $display("FAIL idle_wait: still busy after %0d cycles, required idle", budget);
      end
      #1;
   endtask

   // Requesters: hold each queued operation until it is granted.
   initial begin : driver
      logic [N-1:0] g;
      req_valid = '0;
      req_X     = '0;
      req_Y     = '0;
      forever begin
         @(negedge clk);
         g = req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (g[i]) head[i]++;
            req_valid[i]        = head[i] < tail[i];
            req_X[16*i +: 16]   = qx[i][head[i] % QD];
            req_Y[16*i +: 16]   = qy[i][head[i] % QD];
         end
      end
   end

   // Divider: answers div_lat cycles after the start pulse; div_lat==0 means never.
   initial begin : divider
      logic [15:0] dx, dy;
      int          l;
      div_valid = 1'b0;
      div_quot  = '0;
      div_rem   = '0;
      forever begin
         @(negedge clk);
         if (rst && div_start && div_lat > 0) begin
            dx = div_X;
            dy = div_Y;
            l  = div_lat;
            repeat (l) @(posedge clk);
            #1;
            div_valid = 1'b1;
            div_quot  = dx / dy;
            div_rem   = dx % dy;
            @(posedge clk);
            #1;
            div_valid = 1'b0;
            div_quot  = 16'($urandom);
            div_rem   = 16'($urandom);
         end
      end
   end

   // Transaction-level model and per-cycle comparison.
   initial begin : compare
      exp_t        e, cur;
      logic [N-1:0] eg;
      logic [15:0] mx, my;
      int          j, issue_cyc, busy_until, mptr;
      bit          found, exp_rsp;
      issue_cyc  = -1;
      busy_until = -1;
      mptr       = 0;
      cur        = '{default: 0};
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            exq.delete();
            issue_cyc  = -1;
            busy_until = -1;
            mptr       = 0;
            cur        = '{default: 0};
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_div_start", div_start, 0);
         end else begin
            eg    = '0;
            found = 0;
            j     = 0;
            if (cyc > busy_until) begin
               for (int k = 0; k < N; k++) begin
                  if (!found && req_valid[(mptr + k) % N]) begin
                     j     = (mptr + k) % N;
                     found = 1;
                  end
               end
            end
            if (found) eg[j] = 1'b1;
            chk("req_ready", req_ready, eg);
            if (found) begin
               mx    = req_X[16*j +: 16];
               my    = req_Y[16*j +: 16];
               e.id  = j;
               e.dz  = 0;
               e.err = 0;
               if (my == 0) begin
                  e.q = 16'hFFFF; e.r = mx; e.dz = 1; e.due = cyc + 1;
                  issue_cyc = -1;
               end else if (div_lat >= 1 && div_lat <= T) begin
                  e.q = mx / my; e.r = mx % my; e.due = cyc + 2 + div_lat;
                  issue_cyc = cyc + 1;
               end else begin
                  e.q = 0; e.r = 0; e.err = 1; e.due = cyc + 2 + T;
                  issue_cyc = cyc + 1;
               end
               exq.push_back(e);
               busy_until = e.due;
               mptr = (j + 1) % N;
            end
            if (req_ready != '0) begin
               for (int k = 0; k < N; k++) if (req_ready[k]) gl_id.push_back(k);
               gl_cyc.push_back(cyc);
            end
            chk("div_start", div_start, cyc == issue_cyc);
            if (cyc == issue_cyc) begin
               chk("div_X", div_X, mx);
               chk("div_Y", div_Y, my);
            end
            if (div_start) begin
               starts++;
               st_cyc = cyc;
            end
            exp_rsp = exq.size() > 0 && exq[0].due == cyc;
            chk("rsp_valid", rsp_valid, exp_rsp);
            if (exp_rsp) cur = exq.pop_front();
            chk("rsp_id", rsp_id, cur.id);
            chk("rsp_quot", rsp_quot, cur.q);
            chk("rsp_rem", rsp_rem, cur.r);
            chk("rsp_dz", rsp_dz, cur.dz);
            chk("rsp_err", rsp_err, cur.err);
            if (rsp_valid) rl.push_back('{int'(rsp_id), rsp_quot, rsp_rem, rsp_dz, rsp_err, cyc});
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int rb, gb, sc, n;
      rst     = 1'b0;
      div_lat = 3;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_req_ready", req_ready, 0);
      chk("reset_div_start", div_start, 0);
      chk("reset_rsp_quot", rsp_quot, 0);
      rst = 1'b1;

      // All four at once: strict 0,1,2,3 order, 89 = 4*21 + 5.
      div_lat = 5;
      rb = rl.size(); gb = gl_id.size();
      for (int i = 0; i < N; i++) push(i, 16'd89, 16'd21);
      wait_idle(300);
      chk("all4_count", rl.size(), rb + 4);
      for (int i = 0; i < N; i++) begin
         chk("all4_grant_order", gl_id[gb + i], i);
         chk("all4_rsp_id", rl[rb + i].id, i);
         chk("all4_quot", rl[rb + i].q, 4);
         chk("all4_rem", rl[rb + i].r, 5);
      end

      // Single request: 15 / 8.
      div_lat = 3;
      rb = rl.size(); sc = starts;
      push(0, 16'd15, 16'd8);
      wait_idle(100);
      chk("single_id", rl[rb].id, 0);
      chk("single_quot", rl[rb].q, 1);
      chk("single_rem", rl[rb].r, 7);
      chk("single_dz", rl[rb].dz, 0);
      chk("single_err", rl[rb].err, 0);
      chk("single_starts", starts - sc, 1);

      // Divide by zero from requester 2.
      rb = rl.size(); gb = gl_id.size(); sc = starts;
      push(2, 16'd77, 16'd0);
      wait_idle(100);
      chk("dz_latency", rl[rb].due - gl_cyc[gb], 1);
      chk("dz_id", rl[rb].id, 2);
      chk("dz_flag", rl[rb].dz, 1);
      chk("dz_quot", rl[rb].q, 16'hFFFF);
      chk("dz_rem", rl[rb].r, 77);
      chk("dz_no_start", starts - sc, 0);

      // Divider never answers: timeout after 40 WAIT cycles, then a fresh request.
      div_lat = 0;
      rb = rl.size();
      push(1, 16'd100, 16'd7);
      wait_idle(200);
      chk("to_err", rl[rb].err, 1);
      chk("to_quot", rl[rb].q, 0);
      chk("to_rem", rl[rb].r, 0);
      chk("to_start_to_rsp", rl[rb].due - st_cyc, T + 1);
      div_lat = 2;
      push(3, 16'd9, 16'd3);
      wait_idle(100);
      chk("after_to_id", rl[rb + 1].id, 3);
      chk("after_to_quot", rl[rb + 1].q, 3);
      chk("after_to_err", rl[rb + 1].err, 0);

      // Result on the very last WAIT cycle still wins.
      div_lat = T;
      rb = rl.size();
      push(0, 16'd10, 16'd2);
      wait_idle(200);
      chk("tie_quot", rl[rb].q, 5);
      chk("tie_rem", rl[rb].r, 0);
      chk("tie_err", rl[rb].err, 0);
      chk("tie_start_to_rsp", rl[rb].due - st_cyc, T + 1);

      // Reset mid-WAIT drops the operation and rewinds the pointer.
      div_lat = 0;
      rb = rl.size();
      push(2, 16'd50, 16'd5);
      repeat (8) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_rsp_valid", rsp_valid, 0);
      chk("arst_div_start", div_start, 0);
      chk("arst_req_ready", req_ready, 0);
      chk("arst_div_X", div_X, 0);
      chk("arst_div_Y", div_Y, 0);
      chk("arst_rsp_quot", rsp_quot, 0);
      chk("arst_rsp_id", rsp_id, 0);
      chk("arst_dropped", rl.size(), rb);
      div_lat = 4;
      @(posedge clk);
      #1;
      push(3, 16'd40, 16'd6);
      push(1, 16'd41, 16'd6);
      push(0, 16'd42, 16'd6);
      @(posedge clk);
      #1;
      rst = 1'b1;
      gb = gl_id.size();
      wait_idle(300);
      chk("post_rst_first_grant", gl_id[gb], 0);
      chk("post_rst_rsp_count", rl.size(), rb + 3);
      chk("post_rst_quot", rl[rb].q, 7);

      // Random traffic, checked by the model every cycle.
      for (int b = 0; b < 8; b++) begin
         div_lat = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
         n = $urandom_range(1, 5);
         for (int k = 0; k < n; k++)
            push($urandom_range(0, N - 1), 16'($urandom),
                 ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)));
         wait_idle(600);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
